// File: rtl/csr2_seq_loader.sv
// Sequencer that stages four 32-bit CSR words, pulses them into the csr2
// peripheral, and snapshots the peripheral's readback after a settle window.
module csr2_seq_loader #(
    parameter int unsigned SETTLE    = 2,
    parameter logic [31:0] STAGE_RST = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bus_we,
    input  logic [3:0]   bus_addr,
    input  logic [31:0]  bus_wdata,
    output logic [31:0]  bus_rdata,
    output logic         busy,
    output logic         done_irq,
    output logic         csr2_we,
    output logic [127:0] csr2_wdata,
    output logic [3:0]   csr2_addr,
    input  logic [127:0] csr2_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [3:0]  mask_r;
    logic [31:0] stage_r [4];
    logic [31:0] snap_r  [4];
    logic        done_r;
    logic        ovr_r;

    logic        idle_s;
    logic        ctrl_wr_s;
    logic        commit_s;
    logic        stage_wr_s;
    logic        capture_s;
    logic [3:0]  mask_s;
    logic [31:0] status_s;
    logic [31:0] rdata_s;

    // Bus decode and sequencing conditions
    always_comb begin
        idle_s     = (state_r == IDLE);
        ctrl_wr_s  = bus_we && (bus_addr == 4'd8);
        commit_s   = ctrl_wr_s && bus_wdata[0];
        stage_wr_s = bus_we && (bus_addr[3:2] == 2'b00);
        capture_s  = (state_r == WAIT) && (cnt_r == 4'd1);
        if (bus_wdata[7:4] == 4'h0) begin
            mask_s = 4'hF;
        end else begin
            mask_s = bus_wdata[7:4];
        end
        status_s = {24'h0, mask_r, 1'b0, ovr_r, done_r, busy};
    end

    // Commit sequencer with registered peripheral-side outputs and snapshot capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            mask_r    <= 4'h0;
            csr2_we   <= 1'b0;
            csr2_addr <= 4'h0;
            busy      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap_r[i] <= 32'h0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (commit_s) begin
                        state_r   <= PULSE;
                        mask_r    <= mask_s;
                        csr2_we   <= 1'b1;
                        csr2_addr <= mask_s;
                        busy      <= 1'b1;
                    end else begin
                        csr2_we   <= 1'b0;
                        csr2_addr <= 4'h0;
                        busy      <= 1'b0;
                    end
                end
                PULSE: begin
                    state_r   <= WAIT;
                    cnt_r     <= SETTLE_CNT;
                    csr2_we   <= 1'b0;
                    csr2_addr <= 4'h0;
                    busy      <= 1'b1;
                end
                WAIT: begin
                    if (cnt_r == 4'd1) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            snap_r[i] <= csr2_rdata[32*i +: 32];
                        end
                    end else begin
                        busy    <= 1'b1;
                    end
                    cnt_r <= cnt_r - 4'd1;
                end
                default: begin
                    state_r   <= IDLE;
                    csr2_we   <= 1'b0;
                    csr2_addr <= 4'h0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Staging words; frozen while a sequence is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                stage_r[i] <= STAGE_RST;
            end
        end else if (stage_wr_s && idle_s) begin
            stage_r[bus_addr[1:0]] <= bus_wdata;
        end
    end

    // Sticky flags; a capture or overrun event beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r <= 1'b0;
            ovr_r  <= 1'b0;
        end else begin
            if (capture_s) begin
                done_r <= 1'b1;
            end else if (ctrl_wr_s && bus_wdata[1]) begin
                done_r <= 1'b0;
            end
            if (!idle_s && (stage_wr_s || commit_s)) begin
                ovr_r <= 1'b1;
            end else if (ctrl_wr_s && bus_wdata[2]) begin
                ovr_r <= 1'b0;
            end
        end
    end

    // Read mux
    always_comb begin
        rdata_s = 32'h0;
        case (bus_addr[3:2])
            2'b00: rdata_s = stage_r[bus_addr[1:0]];
            2'b01: rdata_s = snap_r[bus_addr[1:0]];
            2'b10: begin
                if (bus_addr[1:0] == 2'b00) begin
                    rdata_s = status_s;
                end else begin
                    rdata_s = 32'h0;
                end
            end
            default: rdata_s = 32'h0;
        endcase
    end

    // Registered read data, one cycle behind the address
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata <= 32'h0;
        end else begin
            bus_rdata <= rdata_s;
        end
    end

    assign done_irq   = done_r;
    assign csr2_wdata = {stage_r[3], stage_r[2], stage_r[1], stage_r[0]};

endmodule

// File: tb/tb_csr2_seq_loader.sv
// Directed bench for csr2_seq_loader with a small stand-in csr2 peripheral.
module tb_csr2_seq_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         bus_we;
    logic [3:0]   bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         busy;
    logic         done_irq;
    logic         csr2_we;
    logic [127:0] csr2_wdata;
    logic [3:0]   csr2_addr;
    logic [127:0] csr2_rdata;

    int vectors = 0;
    int miscompares = 0;

    csr2_seq_loader #(.SETTLE(2), .STAGE_RST(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .busy       (busy),
        .done_irq   (done_irq),
        .csr2_we    (csr2_we),
        .csr2_wdata (csr2_wdata),
        .csr2_addr  (csr2_addr),
        .csr2_rdata (csr2_rdata)
    );

    always #5 clk = ~clk;

    // Stand-in peripheral: word0 = W1 + 0x100, word1 = W0, words 2/3 pass through
    logic [31:0] per0 = 32'h0, per1 = 32'h0, per2 = 32'h0, per3 = 32'h0;
    always @(posedge clk) begin
        if (csr2_we) begin
            if (csr2_addr[0]) per0 <= csr2_wdata[63:32] + 32'h100;
            if (csr2_addr[1]) per1 <= csr2_wdata[31:0];
            if (csr2_addr[2]) per2 <= csr2_wdata[95:64];
            if (csr2_addr[3]) per3 <= csr2_wdata[127:96];
        end
    end
    assign csr2_rdata = {per3, per2, per1, per0};

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // All tasks start and end #1 after a rising edge
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_we = 1'b0; bus_wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        bus_addr = a;
        @(posedge clk); #1;
        check(tag, 128'(bus_rdata), 128'(exp));
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 32'h0;
        cycles(2);
        rst = 1'b0;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_irq", 128'(done_irq), 128'd0);
        check("rst_we", 128'(csr2_we), 128'd0);
        check("rst_addr", 128'(csr2_addr), 128'd0);
        for (int a = 0; a < 9; a++) begin
            bus_read(4'(a), 32'h0, $sformatf("rst_read%0d", a));
        end

        // First commit, full mask
        bus_write(4'd0, 32'h11111111);
        bus_write(4'd1, 32'h000000FF);
        bus_write(4'd2, 32'hA5A5A5A5);
        bus_write(4'd3, 32'hDEADBEEF);
        bus_write(4'd8, 32'h00000001);
        check("pulse_we", 128'(csr2_we), 128'd1);
        check("pulse_addr", 128'(csr2_addr), 128'hF);
        check("pulse_wdata", csr2_wdata, 128'hDEADBEEF_A5A5A5A5_000000FF_11111111);
        check("pulse_busy", 128'(busy), 128'd1);
        cycles(1);
        check("t1_we", 128'(csr2_we), 128'd0);
        check("t1_busy", 128'(busy), 128'd1);
        cycles(1);
        check("t2_busy", 128'(busy), 128'd1);
        check("t2_irq", 128'(done_irq), 128'd0);
        cycles(1);
        check("t3_busy", 128'(busy), 128'd0);
        check("t3_we", 128'(csr2_we), 128'd0);
        cycles(1);
        check("t4_irq", 128'(done_irq), 128'd1);
        bus_read(4'd4, 32'h000001FF, "snap0");
        bus_read(4'd5, 32'h11111111, "snap1");
        bus_read(4'd6, 32'hA5A5A5A5, "snap2");
        bus_read(4'd7, 32'hDEADBEEF, "snap3");

        // Wrap-around through the peripheral
        bus_write(4'd1, 32'hFFFFFF80);
        bus_write(4'd8, 32'h00000001);
        cycles(4);
        bus_read(4'd4, 32'h00000080, "wrap_snap0");
        bus_read(4'd8, 32'h000000F2, "wrap_status");

        // Writes and commit while busy
        bus_write(4'd8, 32'h00000001);
        bus_write(4'd2, 32'h12345678);
        bus_write(4'd8, 32'h00000001);
        check("ovr_no_pulse", 128'(csr2_we), 128'd0);
        check("ovr_wdata", csr2_wdata, 128'hDEADBEEF_A5A5A5A5_FFFFFF80_11111111);
        cycles(1);
        check("ovr_we", 128'(csr2_we), 128'd0);
        check("ovr_busy", 128'(busy), 128'd0);
        bus_read(4'd8, 32'h000000F6, "ovr_status");
        bus_read(4'd2, 32'hA5A5A5A5, "ovr_w2");

        // Clear-done lands on the capture edge
        bus_write(4'd8, 32'h00000001);
        cycles(2);
        bus_write(4'd8, 32'h00000002);
        check("clr_on_cap", 128'(done_irq), 128'd1);
        bus_write(4'd8, 32'h00000006);
        check("clr_irq", 128'(done_irq), 128'd0);
        bus_read(4'd8, 32'h000000F0, "clr_status");

        // Explicit mask, then commit together with clear-done while done is set
        bus_write(4'd8, 32'h00000031);
        check("mask3_addr", 128'(csr2_addr), 128'h3);
        cycles(3);
        check("mask3_done", 128'(done_irq), 128'd1);
        bus_write(4'd8, 32'h00000023);
        check("cc_irq_cleared", 128'(done_irq), 128'd0);
        check("cc_addr", 128'(csr2_addr), 128'h2);
        cycles(3);
        check("cc_irq_reset", 128'(done_irq), 128'd1);
        bus_read(4'd8, 32'h00000022, "cc_status");

        // Reset in WAIT
        bus_write(4'd8, 32'h00000001);
        cycles(1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("rw_busy", 128'(busy), 128'd0);
        check("rw_we", 128'(csr2_we), 128'd0);
        check("rw_irq", 128'(done_irq), 128'd0);
        bus_read(4'd4, 32'h0, "rw_snap0");
        bus_read(4'd3, 32'h0, "rw_w3");
        bus_read(4'd8, 32'h0, "rw_status");

        // Normal commit after reset
        bus_write(4'd0, 32'h00000005);
        bus_write(4'd1, 32'h00000010);
        bus_write(4'd8, 32'h00000001);
        cycles(3);
        check("post_irq", 128'(done_irq), 128'd1);
        bus_read(4'd4, 32'h00000110, "post_snap0");
        bus_read(4'd5, 32'h00000005, "post_snap1");
        bus_read(4'd6, 32'h00000000, "post_snap2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
